// File: rtl/resposta_tx_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : resposta_tx_sequencer_if                                      |
// | Purpose  : Bundles the response-request handshake and the uart_tx side   |
// |            of resposta_tx_sequencer.                                     |
// | Signals  : resp_valid/resp_ready/resp_codigo/resp_dado  request side     |
// |            tx_start/tx_byte/tx_ativo/tx_concluido        uart_tx side    |
// |            pacote_enviado/erro_timeout                   status pulses   |
// | Modports : master - request source + uart_tx (environment side)          |
// |            slave  - the sequencer itself                                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface resposta_tx_sequencer_if;
   logic       resp_valid;
   logic       resp_ready;
   logic [7:0] resp_codigo;
   logic [7:0] resp_dado;
   logic       tx_start;
   logic [7:0] tx_byte;
   logic       tx_ativo;
   logic       tx_concluido;
   logic       pacote_enviado;
   logic       erro_timeout;

   modport master (
      output resp_valid, resp_codigo, resp_dado, tx_ativo, tx_concluido,
      input  resp_ready, tx_start, tx_byte, pacote_enviado, erro_timeout
   );

   modport slave (
      input  resp_valid, resp_codigo, resp_dado, tx_ativo, tx_concluido,
      output resp_ready, tx_start, tx_byte, pacote_enviado, erro_timeout
   );
endinterface
`default_nettype wire

// File: rtl/resposta_tx_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : resposta_tx_sequencer                                         |
// | Purpose  : Accepts one 2-byte response (code, data) and drives uart_tx   |
// |            to send code byte, an idle gap, then data byte. Reports       |
// |            packet completion or a stalled-transmitter timeout.           |
// | Ports    : clock          system clock (rising edge)                      |
// |            reset_n        synchronous active-low reset                   |
// |            bus (slave)    request handshake, uart_tx control, status     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module resposta_tx_sequencer #(
   parameter int GAP_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 200000,
   parameter int CNT_W          = 18
) (
   input  wire logic              clock,
   input  wire logic              reset_n,
   resposta_tx_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START0 = 3'd1,
      S_WAIT0  = 3'd2,
      S_GAP    = 3'd3,
      S_START1 = 3'd4,
      S_WAIT1  = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] c_gapLast     = CNT_W'(GAP_CYCLES - 1);
   // Counter is 0 in the first WAIT cycle, so giving up when it sits at
   // TIMEOUT_CYCLES-2 puts the error pulse TIMEOUT_CYCLES cycles after start.
   localparam logic [CNT_W-1:0] c_timeoutLast = CNT_W'(TIMEOUT_CYCLES - 2);

   state_t           r_state, w_stateNext;
   logic [CNT_W-1:0] r_cnt, w_cntNext, w_cntInc;
   logic [7:0]       r_codigo, w_codigoNext;
   logic [7:0]       r_dado, w_dadoNext;
   logic             r_respReady, w_respReadyNext;
   logic             r_txStart, w_txStartNext;
   logic [7:0]       r_txByte, w_txByteNext;
   logic             r_pacoteEnviado, w_pacoteNext;
   logic             r_erroTimeout, w_erroNext;

   // uart_tx busy flag is informational only; sequencing relies on the done pulse.
   logic             w_unusedAtivo;
   assign w_unusedAtivo = bus.tx_ativo;

   assign w_cntInc = r_cnt + CNT_W'(1);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state         <= S_IDLE;
         r_cnt           <= '0;
         r_codigo        <= '0;
         r_dado          <= '0;
         r_respReady     <= 1'b1;
         r_txStart       <= 1'b0;
         r_txByte        <= '0;
         r_pacoteEnviado <= 1'b0;
         r_erroTimeout   <= 1'b0;
      end else begin
         r_state         <= w_stateNext;
         r_cnt           <= w_cntNext;
         r_codigo        <= w_codigoNext;
         r_dado          <= w_dadoNext;
         r_respReady     <= w_respReadyNext;
         r_txStart       <= w_txStartNext;
         r_txByte        <= w_txByteNext;
         r_pacoteEnviado <= w_pacoteNext;
         r_erroTimeout   <= w_erroNext;
      end
   end

   // Outputs are computed for the state being entered and registered with it,
   // so every output is valid during the cycle its state is active.
   always_comb begin
      w_stateNext     = r_state;
      w_cntNext       = r_cnt;
      w_codigoNext    = r_codigo;
      w_dadoNext      = r_dado;
      w_respReadyNext = 1'b0;
      w_txStartNext   = 1'b0;
      w_txByteNext    = r_txByte;
      w_pacoteNext    = 1'b0;
      w_erroNext      = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (bus.resp_valid) begin
               w_codigoNext  = bus.resp_codigo;
               w_dadoNext    = bus.resp_dado;
               w_txStartNext = 1'b1;
               w_txByteNext  = bus.resp_codigo;
               w_cntNext     = '0;
               w_stateNext   = S_START0;
            end else begin
               w_respReadyNext = 1'b1;
            end
         end
         S_START0: begin
            w_cntNext   = '0;
            w_stateNext = S_WAIT0;
         end
         S_WAIT0: begin
            // Done is tested first so it wins over a coincident timeout.
            if (bus.tx_concluido) begin
               w_cntNext   = '0;
               w_stateNext = S_GAP;
            end else if (r_cnt == c_timeoutLast) begin
               w_cntNext       = '0;
               w_erroNext      = 1'b1;
               w_respReadyNext = 1'b1;
               w_stateNext     = S_IDLE;
            end else begin
               w_cntNext = w_cntInc;
            end
         end
         S_GAP: begin
            if (r_cnt == c_gapLast) begin
               w_cntNext     = '0;
               w_txStartNext = 1'b1;
               w_txByteNext  = r_dado;
               w_stateNext   = S_START1;
            end else begin
               w_cntNext = w_cntInc;
            end
         end
         S_START1: begin
            w_cntNext   = '0;
            w_stateNext = S_WAIT1;
         end
         S_WAIT1: begin
            if (bus.tx_concluido) begin
               w_cntNext       = '0;
               w_pacoteNext    = 1'b1;
               w_respReadyNext = 1'b1;
               w_stateNext     = S_IDLE;
            end else if (r_cnt == c_timeoutLast) begin
               w_cntNext       = '0;
               w_erroNext      = 1'b1;
               w_respReadyNext = 1'b1;
               w_stateNext     = S_IDLE;
            end else begin
               w_cntNext = w_cntInc;
            end
         end
         default: begin
            w_cntNext       = '0;
            w_respReadyNext = 1'b1;
            w_stateNext     = S_IDLE;
         end
      endcase
   end

   assign bus.resp_ready     = r_respReady;
   assign bus.tx_start       = r_txStart;
   assign bus.tx_byte        = r_txByte;
   assign bus.pacote_enviado = r_pacoteEnviado;
   assign bus.erro_timeout   = r_erroTimeout;

endmodule
`default_nettype wire
